// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing a single-port synchronous-read memory between the
// core and the debug port, with a starvation limit that guarantees debug progress.
module mem_port_arbiter #(
  parameter int AW         = 6,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          own_dbg_q, own_dbg_d;   // owner of the access in flight
  logic          rd_q, rd_d;             // access in flight is a read
  logic          core_gnt_q, core_gnt_d;
  logic          dbg_gnt_q, dbg_gnt_d;
  logic          core_rvalid_q, core_rvalid_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          arb;
  logic          dbg_win;

  assign arb     = (state_q == IDLE) || (state_q == RESP);
  assign dbg_win = dbg_req && (!core_req || (starve_q == STARVE_LIM));

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    own_dbg_d     = own_dbg_q;
    rd_d          = rd_q;
    core_gnt_d    = 1'b0;
    dbg_gnt_d     = 1'b0;
    core_rvalid_d = 1'b0;
    dbg_rvalid_d  = 1'b0;
    dbg_rdata_d   = dbg_rdata_q;
    mem_en_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      BUSY: begin
        state_d       = RESP;
        core_rvalid_d = !own_dbg_q && rd_q;
      end
      RESP: begin
        // mem_rdata is valid during RESP; debug keeps a registered copy
        if (own_dbg_q && rd_q) begin
          dbg_rdata_d  = mem_rdata;
          dbg_rvalid_d = 1'b1;
        end
      end
      IDLE: ;
      default: state_d = IDLE;
    endcase

    if (arb) begin
      if (core_req || dbg_req) begin
        state_d   = BUSY;
        mem_en_d  = 1'b1;
        own_dbg_d = dbg_win;
        if (dbg_win) begin
          mem_we_d    = dbg_we;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
          rd_d        = !dbg_we;
          dbg_gnt_d   = 1'b1;
        end else begin
          mem_we_d    = core_we;
          mem_addr_d  = core_addr;
          mem_wdata_d = core_wdata;
          rd_d        = !core_we;
          core_gnt_d  = 1'b1;
        end
      end else begin
        state_d = IDLE;
      end
      // Counts core wins over a waiting debug request, saturating at the limit
      if (!dbg_req || dbg_win) starve_d = 4'd0;
      else if (starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      starve_q      <= 4'd0;
      own_dbg_q     <= 1'b0;
      rd_q          <= 1'b0;
      core_gnt_q    <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      dbg_rdata_q   <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      own_dbg_q     <= own_dbg_d;
      rd_q          <= rd_d;
      core_gnt_q    <= core_gnt_d;
      dbg_gnt_q     <= dbg_gnt_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      dbg_rdata_q   <= dbg_rdata_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign core_gnt    = core_gnt_q;
  assign dbg_gnt     = dbg_gnt_q;
  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = mem_rdata;
  assign dbg_rvalid  = dbg_rvalid_q;
  assign dbg_rdata   = dbg_rdata_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous-read memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [5:0]  core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic        core_gnt, core_rvalid;
  logic [15:0] core_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [5:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] mem [64];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(6), .DW(16), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous read, data valid the cycle after mem_en
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {mem_en, mem_we, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid}, 32'd0);
    chk({tag, "_addr"}, {26'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({tag, "_drdata"}, {16'd0, dbg_rdata}, 32'd0);
  endtask

  task automatic dbg_read5(input string tag);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
    tick();
    chk({tag, "_gnt"}, {dbg_gnt, core_gnt, mem_en, mem_we}, 32'b1010);
    chk({tag, "_addr"}, {26'd0, mem_addr}, 32'd5);
    dbg_req = 1'b0;
    tick();
    chk({tag, "_resp"}, {dbg_gnt, mem_en, dbg_rvalid}, 32'b000);
    tick();
    chk({tag, "_rvalid"}, {31'd0, dbg_rvalid}, 32'd1);
    chk({tag, "_rdata"}, {16'd0, dbg_rdata}, 32'h1234);
    tick();
    chk({tag, "_hold"}, {15'd0, dbg_rvalid, dbg_rdata}, 32'h1234);
  endtask

  initial begin
    int ng;
    bit stop;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    pre_we = 1'b1; pre_addr = 6'd5; pre_data = 16'h1234;
    tick();
    pre_we = 1'b0;
    tick();
    chk_all_zero("reset");
    rst = 1'b1;

    // Debug read alone
    dbg_read5("dbg_rd");

    // Core write 0xBEEF to 12, idle cycle, then read back
    core_req = 1'b1; core_we = 1'b1; core_addr = 6'd12; core_wdata = 16'hBEEF;
    tick();
    chk("cw_gnt", {core_gnt, dbg_gnt, mem_en, mem_we}, 32'b1011);
    chk("cw_bus", {10'd0, mem_addr, mem_wdata}, {10'd0, 6'd12, 16'hBEEF});
    core_req = 1'b0;
    tick();
    chk("cw_resp", {core_gnt, mem_en, mem_we, core_rvalid}, 32'b0000);
    tick();
    chk("cw_idle", {core_gnt, mem_en}, 32'b00);
    core_req = 1'b1; core_we = 1'b0;
    tick();
    chk("cr_gnt", {core_gnt, mem_en, mem_we}, 32'b110);
    core_req = 1'b0;
    tick();
    chk("cr_rvalid", {15'd0, core_rvalid, core_rdata}, {15'd0, 1'b1, 16'hBEEF});

    // Simultaneous requests: core first, debug at the next RESP
    tick();
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'd12;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
    tick();
    chk("sim_t1", {core_gnt, dbg_gnt, 26'd0, mem_addr}, {1'b1, 1'b0, 26'd0, 6'd12});
    core_req = 1'b0;
    tick();
    chk("sim_t2", {core_gnt, dbg_gnt, core_rvalid, core_rdata}, {3'b001, 16'hBEEF});
    tick();
    chk("sim_t3", {core_gnt, dbg_gnt, 26'd0, mem_addr}, {1'b0, 1'b1, 26'd0, 6'd5});
    dbg_req = 1'b0;
    tick();
    tick();
    chk("sim_t5", {15'd0, dbg_rvalid, dbg_rdata}, {15'd0, 1'b1, 16'h1234});
    tick();

    // Starvation: both held high, expect C,C,C,C,D,C,C,C,C,D
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'd12;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
    ng = 0;
    stop = 1'b0;
    for (int c = 0; c < 40 && !stop; c++) begin
      tick();
      if (core_gnt || dbg_gnt) begin
        chk($sformatf("starve_g%0d", ng), {30'd0, core_gnt, dbg_gnt},
            (ng % 5 == 4) ? 32'b01 : 32'b10);
        ng++;
        if (ng == 10) begin
          core_req = 1'b0; dbg_req = 1'b0;
          stop = 1'b1;
        end
      end
    end
    chk("starve_count", ng, 32'd10);
    core_req = 1'b0; dbg_req = 1'b0;
    repeat (4) tick();

    // Reset during BUSY of a debug read
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd5;
    tick();
    chk("rst_pre_gnt", {31'd0, dbg_gnt}, 32'd1);
    #2 rst = 1'b0;
    dbg_req = 1'b0;
    #1 chk_all_zero("rst_mid");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst_hold%0d", c), {15'd0, dbg_rvalid, dbg_rdata}, 32'd0);
    end
    rst = 1'b1;
    tick();
    dbg_read5("rst_retry");

    // Idle: no activity, mem_addr holds
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("idle%0d", c),
          {21'd0, mem_en, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, mem_addr},
          {21'd0, 5'b0, 6'd5});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port 16-bit data memory between the multicycle core's memory interface and the FPGA debug/user port that reads and writes memory by index. It sits between the core datapath and the memory array. It serialises accesses, returns read data to the winning requester and guarantees the debug port forward progress while the core is running.

## Interface

Parameters:
- AW, 6: memory address width (matches the 6-bit user index).
- DW, 16: data width.
- STARVE_MAX, 4: consecutive core grants allowed while dbg_req is pending; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- core_req  in  1  core access request; held until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core write data.
- core_gnt  out  1  one-cycle pulse; the request was issued to memory this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DW  core read data (combinational pass-through of mem_rdata).
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug request bundle; same rules as the core bundle.
- dbg_gnt  out  1  one-cycle grant pulse.
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata updated.
- dbg_rdata  out  DW  registered hold of the last debug read; drives the user display.
- mem_en, mem_we  out  1  registered memory strobes.
- mem_addr  out  AW  registered memory address.
- mem_wdata  out  DW  registered memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en (synchronous read).

## Operation

- FSM states: IDLE, BUSY, RESP. Reset state is IDLE.
- Arbitration is evaluated in IDLE and RESP.
- If no request is present, the next state is IDLE.
- If any request is present, the next state is BUSY. The winner's we/addr/wdata are registered onto the mem_* outputs, mem_en is set to 1, and the winner's gnt is set to 1.
- Winner selection:
  - Core wins by default.
  - Debug wins if only dbg_req is high, or if starve_cnt == STARVE_MAX.
- starve_cnt (4-bit):
  - Increments on each core grant made while dbg_req is high.
  - Clears on any debug grant.
  - Clears at any arbitration where dbg_req is low.
  - Saturates at STARVE_MAX.
- BUSY always transitions to RESP. mem_en, mem_we and gnt are 0 in every state except BUSY. mem_addr and mem_wdata hold their last values.
- RESP:
  - Core read: core_rvalid = 1 for this cycle.
  - Debug read: dbg_rdata <= mem_rdata at the end of RESP, and dbg_rvalid pulses in the following cycle.
  - Writes produce no rvalid.
- Requesters deassert req, or present a new request, in the cycle after gnt. A req still high in RESP is treated as a new request.
- Simultaneous requests are resolved by the priority and starvation rules above. The loser keeps req high and is not dropped.

## Timing

- Reset (rst low, asynchronous): state = IDLE; starve_cnt = 0; every output = 0, including mem_addr, mem_wdata and dbg_rdata.
- Reset asserted mid-access: the access is abandoned with no rvalid. The requester re-requests after reset.
- Single read, request seen in IDLE at cycle T:
  - gnt and mem_en at T+1.
  - core_rvalid with core_rdata at T+2.
  - For debug, dbg_rvalid at T+3, with dbg_rdata stable from T+3 onward.
- Throughput: one access per 2 cycles with back-to-back requests (RESP re-arbitrates directly into BUSY).
- Write: mem_we = mem_en = 1 at T+1; the memory updates at the end of T+1.
- Core stall bound with dbg_req continuously high: at most STARVE_MAX consecutive core accesses, then exactly one debug access.

## Test plan

- Debug read alone: dbg_req, addr 5, memory[5] = 0x1234 -> dbg_gnt at T+1, dbg_rvalid at T+3, dbg_rdata = 0x1234 held until the next debug read.
- Core write then core read: write 0xBEEF to addr 12, then read addr 12 -> mem_we = 1 only in the first BUSY; core_rvalid with core_rdata = 0xBEEF four cycles after the first grant.
- Simultaneous requests: core_req and dbg_req both high in the same IDLE cycle -> core granted first, debug granted at the next RESP, two cycles later.
- Starvation with STARVE_MAX = 4: core_req and dbg_req held high continuously -> grant sequence C,C,C,C,D,C,C,C,C,D; starve_cnt never exceeds 4.
- Reset mid-access: rst low during BUSY of a debug read -> all outputs 0 immediately, no dbg_rvalid, dbg_rdata = 0; after release, the repeated request completes normally.
- Idle: no requests for 20 cycles -> mem_en = 0 and no gnt or rvalid pulses; mem_addr holds its last value.
